// File: rtl/time_setup_if.sv
// Setup load bus between the front-panel time-setting controller and the
// hours/minutes/seconds counters. The controller is the master: it reads the
// current counter values and drives the load pulses, load value, run enable
// and the selected field for the display.
interface time_setup_if;
    logic [7:0] cur_hours;
    logic [7:0] cur_minutes;
    logic [7:0] cur_seconds;
    logic       setup_imp_h;
    logic       setup_imp_m;
    logic       setup_imp_s;
    logic [7:0] setup_data;
    logic       run_en;
    logic [1:0] field_sel;

    modport master (
        input  cur_hours, cur_minutes, cur_seconds,
        output setup_imp_h, setup_imp_m, setup_imp_s, setup_data, run_en, field_sel
    );

    modport slave (
        output cur_hours, cur_minutes, cur_seconds,
        input  setup_imp_h, setup_imp_m, setup_imp_s, setup_data, run_en, field_sel
    );
endinterface

// File: rtl/time_setup_ctrl.sv
// Front-panel time-setting controller.
// Debounces the mode/up/down buttons, walks RUN -> SET_H -> SET_M -> SET_S -> RUN
// on mode presses and, while a field is selected, issues one-cycle load pulses
// carrying the stepped field value to the matching counter. The time chain is
// frozen (run_en low) whenever a field is being set.
module time_setup_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int HOUR_MAX   = 23,
    parameter int MIN_MAX    = 59,
    parameter int SEC_MAX    = 59
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          btn_mode,
    input  logic          btn_up,
    input  logic          btn_down,
    time_setup_if.master  setup
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } ctrlState_t;

    // Button index 0 = mode, 1 = up, 2 = down
    logic [2:0]    btnRaw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    level_q;
    logic [2:0]    level_d;
    logic [CW-1:0] debCnt_q [3];
    logic [CW-1:0] debCnt_d [3];
    logic [2:0]    btnEvent;

    logic       modeEvt;
    logic       upEvt;
    logic       downEvt;

    ctrlState_t state_q;
    ctrlState_t state_d;
    logic [7:0] shadow_q;
    logic [7:0] shadow_d;
    logic [7:0] setupData_q;
    logic [7:0] setupData_d;
    logic       impH_q;
    logic       impH_d;
    logic       impM_q;
    logic       impM_d;
    logic       impS_q;
    logic       impS_d;
    logic       runEn_q;
    logic [1:0] fieldSel_q;
    logic [7:0] fieldMax;
    logic [7:0] stepVal;

    assign btnRaw = {btn_down, btn_up, btn_mode};

    // Two-flop synchronisers bring the raw asynchronous buttons into the clock domain
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btnRaw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a level change is accepted only after the synced input has disagreed with
    // the debounced level for DEB_CYCLES consecutive cycles; the 0->1 acceptance is the press event
    always_comb begin
        level_d  = level_q;
        btnEvent = '0;
        for (int i = 0; i < 3; i++) begin
            debCnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (debCnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    level_d[i]  = sync2_q[i];
                    btnEvent[i] = sync2_q[i];
                end else begin
                    debCnt_d[i] = debCnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels and their stability counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
            for (int i = 0; i < 3; i++) begin
                debCnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int i = 0; i < 3; i++) begin
                debCnt_q[i] <= debCnt_d[i];
            end
        end
    end

    assign modeEvt = btnEvent[0];
    assign upEvt   = btnEvent[1];
    assign downEvt = btnEvent[2];

    // Upper limit of the field currently being edited
    always_comb begin
        fieldMax = 8'd0;
        case (state_q)
            SET_H:   fieldMax = 8'(HOUR_MAX);
            SET_M:   fieldMax = 8'(MIN_MAX);
            SET_S:   fieldMax = 8'(SEC_MAX);
            default: fieldMax = 8'd0;
        endcase
    end

    // Stepped value: up wraps past the maximum to 0, down wraps from 0 (or out-of-range) to the maximum
    always_comb begin
        stepVal = shadow_q;
        if (upEvt) begin
            stepVal = (shadow_q >= fieldMax) ? 8'd0 : shadow_q + 8'd1;
        end else begin
            stepVal = (shadow_q == 8'd0 || shadow_q > fieldMax) ? fieldMax : shadow_q - 8'd1;
        end
    end

    // Next state and load pulses: mode beats up/down, and up together with down cancels out
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        setupData_d = setupData_q;
        impH_d      = 1'b0;
        impM_d      = 1'b0;
        impS_d      = 1'b0;
        if (modeEvt) begin
            case (state_q)
                RUN: begin
                    state_d  = SET_H;
                    shadow_d = setup.cur_hours;
                end
                SET_H: begin
                    state_d  = SET_M;
                    shadow_d = setup.cur_minutes;
                end
                SET_M: begin
                    state_d  = SET_S;
                    shadow_d = setup.cur_seconds;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end else if (state_q != RUN && (upEvt ^ downEvt)) begin
            shadow_d    = stepVal;
            setupData_d = stepVal;
            case (state_q)
                SET_H:   impH_d = 1'b1;
                SET_M:   impM_d = 1'b1;
                SET_S:   impS_d = 1'b1;
                default: ;
            endcase
        end
    end

    // State, shadow value and registered outputs; run_en and field_sel follow the new state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            shadow_q    <= '0;
            setupData_q <= '0;
            impH_q      <= 1'b0;
            impM_q      <= 1'b0;
            impS_q      <= 1'b0;
            runEn_q     <= 1'b1;
            fieldSel_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            setupData_q <= setupData_d;
            impH_q      <= impH_d;
            impM_q      <= impM_d;
            impS_q      <= impS_d;
            runEn_q     <= (state_d == RUN);
            fieldSel_q  <= state_d;
        end
    end

    assign setup.setup_imp_h = impH_q;
    assign setup.setup_imp_m = impM_q;
    assign setup.setup_imp_s = impS_q;
    assign setup.setup_data  = setupData_q;
    assign setup.run_en      = runEn_q;
    assign setup.field_sel   = fieldSel_q;

endmodule
